// File: rtl/karplus_strong_voice_pkg.sv
// Shared types, control-word field positions, LFSR constants and length clamp
// for the Karplus-Strong plucked-string voice.
package karplus_pkg;

  localparam int unsigned MAX_LEN   = 2048;
  localparam int unsigned LEN_W     = 11;
  localparam int unsigned DATA_W    = 16;
  localparam int unsigned AMP_SHIFT = 1;

  localparam logic [DATA_W-1:0] LFSR_SEED = 16'hACE1;
  localparam logic [DATA_W-1:0] LFSR_TAPS = 16'hB400;

  localparam int unsigned PLUCK_BIT = 15;
  localparam int unsigned DAMP_MSB  = 14;
  localparam int unsigned DAMP_LSB  = 11;
  localparam int unsigned LEN_MSB   = 10;
  localparam int unsigned LEN_LSB   = 0;

  localparam logic [LEN_W-1:0] LEN_MIN = LEN_W'(2);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN - 1);

  typedef enum logic [1:0] {IDLE, FILL, PLAY} ks_state_e;

  // Shortest usable loop is two words; the top limit is the field maximum.
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] n);
    return (n < LEN_MIN) ? LEN_MIN : n;
  endfunction

  // One step of the 16-bit Galois noise generator.
  function automatic logic [DATA_W-1:0] lfsr_step(input logic [DATA_W-1:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

endpackage

// File: rtl/karplus_strong_voice_if.sv
// Control/sample bundle between the PIO/mixer side and one voice.
interface karplus_strong_voice_if;
  import karplus_pkg::*;

  logic [DATA_W-1:0] ctrl_word;
  logic              sample_tick;
  logic [DATA_W-1:0] sample_out;
  logic              sample_valid;
  logic              busy;
  logic              overrun;

  modport master (
    output ctrl_word, sample_tick,
    input  sample_out, sample_valid, busy, overrun
  );

  modport slave (
    input  ctrl_word, sample_tick,
    output sample_out, sample_valid, busy, overrun
  );
endinterface

// File: rtl/karplus_strong_voice_ram.sv
// Delay line: simple dual-port RAM with a registered read port (1-clock latency).
module ks_delay_ram
  import karplus_pkg::*;
(
  input  logic              clk,
  input  logic              we_i,
  input  logic [LEN_W-1:0]  waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [LEN_W-1:0]  raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem [0:LEN_MAX];

  // Write port.
  always_ff @(posedge clk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  // Registered read port.
  always_ff @(posedge clk) begin
    if (re_i) rdata_o <= mem[raddr_i];
  end

endmodule

// File: rtl/karplus_strong_voice.sv
// One Karplus-Strong plucked-string voice: noise fill of the delay line on a
// pluck, then one averaged sample per sample_tick through RD/CALC/WB stages.
// Optional feature macro: KS_DAMPING_EN (extra per-pluck damping on write-back).
module karplus_strong_voice
  import karplus_pkg::*;
(
  input logic                   clk_clk,
  input logic                   reset_reset_n,
  karplus_strong_voice_if.slave bus
);

  ks_state_e         state_q, state_d;
  logic [DATA_W-1:0] ctrl_q, ctrl_d;
  logic              pluck_prev_q, pluck_prev_d;
  logic [LEN_W-1:0]  len_q, len_d, ptr_q, ptr_d;
  logic [DATA_W-1:0] lfsr_q, lfsr_d, prev_q, prev_d, a_q, a_d, out_q, out_d;
  logic              s1_q, s1_d, s2_q, s2_d;
  logic              valid_q, valid_d, busy_q, busy_d, ovr_q, ovr_d;

  logic                     pluck_c, tick_ok_c, tick_ovr_c, ptr_last_c, ram_we_c;
  logic signed [DATA_W-1:0] lfsr_s_c, fill_word_c;
  logic [DATA_W-1:0]        ram_wdata_c, ram_rdata, y_c;
  logic [DATA_W:0]          sum_c;

`ifdef KS_DAMPING_EN
  logic [3:0]           damp_q, damp_d;
  logic signed [DATA_W:0] y_ext_c, att_c, diff_c;
`else
  logic unused_damp;
  assign unused_damp = ^ctrl_q[DAMP_MSB:DAMP_LSB];
`endif

  // Pluck edge, tick qualification and RAM port control.
  always_comb begin
    pluck_c     = ctrl_q[PLUCK_BIT] & ~pluck_prev_q;
    tick_ok_c   = bus.sample_tick & (state_q == PLAY) & ~s1_q & ~s2_q & ~pluck_c;
    tick_ovr_c  = bus.sample_tick & (state_q == PLAY) & (s1_q | s2_q) & ~pluck_c;
    ptr_last_c  = (ptr_q == len_q - LEN_W'(1));
    ram_we_c    = ~pluck_c & ((state_q == FILL) | ((state_q == PLAY) & s2_q));
    lfsr_s_c    = lfsr_q;
    fill_word_c = lfsr_s_c >>> AMP_SHIFT;
    ram_wdata_c = (state_q == FILL) ? DATA_W'(fill_word_c) : out_q;
  end

  // CALC: two-tap average of the delay-line word and the previous word.
  always_comb begin
    sum_c = {ram_rdata[DATA_W-1], ram_rdata} + {prev_q[DATA_W-1], prev_q};
    y_c   = sum_c[DATA_W:1];
`ifdef KS_DAMPING_EN
    y_ext_c = $signed({y_c[DATA_W-1], y_c});
    att_c   = y_ext_c >>> (5'(damp_q) + 5'd1);
    diff_c  = y_ext_c - att_c;
    if (damp_q != 4'd0) begin
      if (diff_c[DATA_W] != diff_c[DATA_W-1])
        y_c = diff_c[DATA_W] ? 16'h8000 : 16'h7FFF;
      else
        y_c = diff_c[DATA_W-1:0];
    end
`endif
  end

  // Next-state: pluck restarts the fill from anywhere; otherwise FILL/PLAY work.
  always_comb begin
    state_d      = state_q;
    ctrl_d       = bus.ctrl_word;
    pluck_prev_d = ctrl_q[PLUCK_BIT];
    len_d        = len_q;
    ptr_d        = ptr_q;
    lfsr_d       = lfsr_q;
    prev_d       = prev_q;
    a_d          = a_q;
    out_d        = out_q;
    s1_d         = 1'b0;
    s2_d         = 1'b0;
    valid_d      = 1'b0;
    busy_d       = busy_q;
    ovr_d        = ovr_q;
`ifdef KS_DAMPING_EN
    damp_d       = damp_q;
`endif
    if (pluck_c) begin
      len_d   = clamp_len(ctrl_q[LEN_MSB:LEN_LSB]);
`ifdef KS_DAMPING_EN
      damp_d  = ctrl_q[DAMP_MSB:DAMP_LSB];
`endif
      ptr_d   = '0;
      ovr_d   = 1'b0;
      busy_d  = 1'b1;
      state_d = FILL;
    end else begin
      unique case (state_q)
        FILL: begin
          lfsr_d = lfsr_step(lfsr_q);
          if (ptr_last_c) begin
            ptr_d   = '0;
            prev_d  = '0;
            busy_d  = 1'b0;
            state_d = PLAY;
          end else begin
            ptr_d = ptr_q + LEN_W'(1);
          end
        end
        PLAY: begin
          s1_d = tick_ok_c;
          s2_d = s1_q;
          if (tick_ovr_c) ovr_d = 1'b1;
          if (s1_q) begin
            a_d     = ram_rdata;
            out_d   = y_c;
            valid_d = 1'b1;
          end
          if (s2_q) begin
            prev_d = a_q;
            ptr_d  = ptr_last_c ? '0 : ptr_q + LEN_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q      <= IDLE;
      ctrl_q       <= '0;
      pluck_prev_q <= 1'b0;
      len_q        <= LEN_MIN;
      ptr_q        <= '0;
      lfsr_q       <= LFSR_SEED;
      prev_q       <= '0;
      a_q          <= '0;
      out_q        <= '0;
      s1_q         <= 1'b0;
      s2_q         <= 1'b0;
      valid_q      <= 1'b0;
      busy_q       <= 1'b0;
      ovr_q        <= 1'b0;
`ifdef KS_DAMPING_EN
      damp_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      ctrl_q       <= ctrl_d;
      pluck_prev_q <= pluck_prev_d;
      len_q        <= len_d;
      ptr_q        <= ptr_d;
      lfsr_q       <= lfsr_d;
      prev_q       <= prev_d;
      a_q          <= a_d;
      out_q        <= out_d;
      s1_q         <= s1_d;
      s2_q         <= s2_d;
      valid_q      <= valid_d;
      busy_q       <= busy_d;
      ovr_q        <= ovr_d;
`ifdef KS_DAMPING_EN
      damp_q       <= damp_d;
`endif
    end
  end

  ks_delay_ram u_ram (
    .clk     (clk_clk),
    .we_i    (ram_we_c),
    .waddr_i (ptr_q),
    .wdata_i (ram_wdata_c),
    .re_i    (tick_ok_c),
    .raddr_i (ptr_q),
    .rdata_o (ram_rdata)
  );

  assign bus.sample_out   = out_q;
  assign bus.sample_valid = valid_q;
  assign bus.busy         = busy_q;
  assign bus.overrun      = ovr_q;

endmodule
